// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared state encodings and default widths for the FIFO read streamer
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DRAIN  = 2'b10
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port and output stream signals of the read streamer
interface fifo_rd_stream_if
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              fifo_rd;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  // streamer side: issues reads, sources the stream
  modport master (
    output fifo_rd,
    output m_data,
    output m_valid,
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready
  );

  // environment side: FIFO read port and stream sink
  modport slave (
    input  fifo_rd,
    input  m_data,
    input  m_valid,
    output fifo_empty,
    output fifo_dout,
    output m_ready
  );

endinterface

// File: rtl/stream_buf.sv
// rtl/stream_buf.sv - circular output buffer holding words returned by the FIFO
module stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  BUF_D  = 3,
  localparam int PTR_W  = $clog2(BUF_D),
  localparam int OCC_W  = $clog2(BUF_D + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] mem [BUF_D];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ_q;
  logic              pop_ok;

  // pointers wrap at BUF_D, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // a pop of an empty buffer is ignored so occ can never underflow
  assign pop_ok    = pop & (occ_q != '0);
  assign head_data = mem[rd_ptr];
  assign occ       = occ_q;

  // storage, pointer and occupancy update; push+pop together leaves occ unchanged
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      for (int i = 0; i < BUF_D; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop_ok})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - turns a one-cycle-latency FIFO read port into a valid/ready stream
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BUF_D  = 3,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  fifo_rd_stream_if.master     bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_cnt
);

  localparam int OCC_W = $clog2(BUF_D + 1);

  state_t             state_q;
  state_t             state_d;
  logic               inflight_q;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W:0]     pending;
  logic               rd_ok;
  logic               xfer;

  // words already promised to the buffer: stored plus the one still on the FIFO bus
  assign pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};

  // read gate uses only registers and fifo_empty, so m_ready never reaches fifo_rd
  assign rd_ok       = (state_q == ACTIVE) & ~bus.fifo_empty & (pending < (OCC_W + 1)'(BUF_D));
  assign bus.fifo_rd = rd_ok;

  assign bus.m_valid = (occ != '0);
  assign xfer        = bus.m_valid & bus.m_ready;
  assign busy        = (state_q != IDLE);

  // read data arrives the cycle after the accepted read, so inflight is the push strobe
  stream_buf #(
    .DATA_W (DATA_W),
    .BUF_D  (BUF_D)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (bus.fifo_dout),
    .pop       (xfer),
    .head_data (bus.m_data),
    .occ       (occ)
  );

  // state register and in-flight read marker
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_ok;
    end
  end

  // next state: DRAIN keeps delivering buffered/in-flight words without new reads
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!en) state_d = ((occ != '0) || inflight_q) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (en)                                state_d = ACTIVE;
        else if ((occ == '0) && !inflight_q)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // completed output handshakes, wrapping at the counter width
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (xfer) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int BD = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          force_empty = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  int            up_n = 0;
  logic          fifo_empty;

  logic          busy_a;
  logic          busy_b;
  logic [15:0]   cnt_a;
  logic [3:0]    cnt_b;

  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_W(DW)) bus_a ();
  fifo_rd_stream_if #(.DATA_W(DW)) bus_b ();

  assign fifo_empty       = force_empty | (up_n == 0);
  assign bus_a.fifo_empty = fifo_empty;
  assign bus_b.fifo_empty = fifo_empty;
  assign bus_a.fifo_dout  = fifo_dout;
  assign bus_b.fifo_dout  = fifo_dout;
  assign bus_a.m_ready    = m_ready;
  assign bus_b.m_ready    = m_ready;

  fifo_rd_stream #(.DATA_W(DW), .BUF_D(BD), .CNT_W(16)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus_a),
    .busy     (busy_a),
    .word_cnt (cnt_a)
  );

  fifo_rd_stream #(.DATA_W(DW), .BUF_D(BD), .CNT_W(4)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus_b),
    .busy     (busy_b),
    .word_cnt (cnt_b)
  );

  // upstream FIFO contents, load/flush requests, delivered-word log
  logic [DW-1:0] up_q[$];
  logic [DW-1:0] log_q[$];
  int            log_cyc[$];
  int            acc_cnt = 0;
  int            cyc = 0;
  logic [DW-1:0] ld_first = '0;
  int            ld_num = 0;
  int            ld_seq = 0;
  int            ld_done = 0;
  int            fl_seq = 0;
  int            fl_done = 0;

  // reference model: buffered words in order, one word on the FIFO bus, mode, transfer count
  int            m_st = 0;
  logic [DW-1:0] exp_q[$];
  bit            fly = 1'b0;
  logic [DW-1:0] fly_w = '0;
  int            exp_cnt = 0;

  int            checks = 0;
  int            errors = 0;
  int            viol = 0;
  int            first_rd = -1;
  int            first_v = -1;

  function automatic bit exp_rd_f();
    return (m_st == 1) && !fifo_empty && ((exp_q.size() + int'(fly)) < BD);
  endfunction

  // FIFO environment and model advance on every rising edge
  always @(posedge clk) begin : env_model
    bit rd_m;
    bit hs_m;
    int nsz;
    cyc = cyc + 1;
    if (rst && bus_a.m_valid && m_ready) begin
      log_q.push_back(bus_a.m_data);
      log_cyc.push_back(cyc);
    end
    if (!rst) begin
      m_st = 0;
      exp_q.delete();
      fly = 1'b0;
      exp_cnt = 0;
    end else begin
      rd_m = exp_rd_f();
      hs_m = (exp_q.size() != 0) && m_ready;
      nsz  = exp_q.size() + int'(fly);
      case (m_st)
        0: if (en) m_st = 1;
        1: if (!en) m_st = (nsz != 0) ? 2 : 0;
        default: begin
          if (en) m_st = 1;
          else if (nsz == 0) m_st = 0;
        end
      endcase
      if (hs_m) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 1;
      end
      if (fly) exp_q.push_back(fly_w);
      fly = rd_m;
      if (rd_m && up_q.size() > 0) fly_w = up_q[0];
    end
    if (bus_a.fifo_rd && up_q.size() > 0) begin
      fifo_dout <= up_q[0];
      void'(up_q.pop_front());
      acc_cnt = acc_cnt + 1;
    end
    if (fl_seq != fl_done) begin
      up_q.delete();
      fl_done = fl_seq;
    end
    if (ld_seq != ld_done) begin
      for (int i = 0; i < ld_num; i++) up_q.push_back(ld_first + DW'(i));
      ld_done = ld_seq;
    end
    up_n <= up_q.size();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // per-cycle comparison of both DUTs against the model
  task automatic compare();
    bit erd;
    bit ev;
    erd = exp_rd_f();
    ev  = (exp_q.size() != 0);
    chk("fifo_rd_a", {31'd0, bus_a.fifo_rd}, {31'd0, erd});
    chk("fifo_rd_b", {31'd0, bus_b.fifo_rd}, {31'd0, erd});
    chk("m_valid_a", {31'd0, bus_a.m_valid}, {31'd0, ev});
    chk("m_valid_b", {31'd0, bus_b.m_valid}, {31'd0, ev});
    if (ev) begin
      chk("m_data_a", {24'd0, bus_a.m_data}, {24'd0, exp_q[0]});
      chk("m_data_b", {24'd0, bus_b.m_data}, {24'd0, exp_q[0]});
    end
    chk("busy_a", {31'd0, busy_a}, {31'd0, (m_st != 0)});
    chk("busy_b", {31'd0, busy_b}, {31'd0, (m_st != 0)});
    chk("word_cnt_a", {16'd0, cnt_a}, {16'd0, exp_cnt[15:0]});
    chk("word_cnt_b", {28'd0, cnt_b}, {28'd0, exp_cnt[3:0]});
    if (bus_a.fifo_rd && fifo_empty) viol = viol + 1;
    if (bus_a.fifo_rd && first_rd < 0) first_rd = cyc;
    if (bus_a.m_valid && first_v < 0) first_v = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [DW-1:0] first, input int n);
    ld_first = first;
    ld_num   = n;
    ld_seq   = ld_seq + 1;
  endtask

  task automatic flush();
    fl_seq = fl_seq + 1;
  endtask

  task automatic wait_deliv(input int target, input int budget);
    int k;
    k = 0;
    while (log_q.size() < target && k < budget) begin
      step();
      k++;
    end
    if (log_q.size() < target) chk("deliver_timeout", log_q.size(), target);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy_a && k < budget) begin
      step();
      k++;
    end
    chk("idle_reached", {31'd0, busy_a}, 32'd0);
  endtask

  initial begin : stim
    int base;
    int acc0;
    int k;

    // reset held with en=1 and a non-empty FIFO
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    load(8'h01, 16);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_fifo_rd", {31'd0, bus_a.fifo_rd}, 32'd0);
      chk("rst_m_valid", {31'd0, bus_a.m_valid}, 32'd0);
      chk("rst_word_cnt", {16'd0, cnt_a}, 32'd0);
      chk("rst_m_data", {24'd0, bus_a.m_data}, 32'd0);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_fifo_empty", {31'd0, fifo_empty}, 32'd0);
    end

    // streaming 0x01..0x10 at full rate
    first_rd = -1; first_v = -1;
    base = log_q.size();
    rst = 1'b1;
    wait_deliv(base + 16, 100);
    if (log_q.size() >= base + 16) begin
      chk("stream_latency", first_v - first_rd, 2);
      for (int i = 0; i < 16; i++) chk("stream_word", {24'd0, log_q[base + i]}, i + 1);
      chk("stream_rate", log_cyc[base + 15] - log_cyc[base], 15);
    end
    chk("stream_cnt_a", {16'd0, cnt_a}, 32'd16);
    chk("stream_cnt_b", {28'd0, cnt_b}, 32'd0);
    en = 1'b0;
    wait_idle(50);

    // backpressure with 20 words available
    m_ready = 1'b0;
    base = log_q.size();
    acc0 = acc_cnt;
    load(8'h01, 20);
    en = 1'b1;
    repeat (10) step();
    chk("bp_accepted", acc_cnt - acc0, BD);
    chk("bp_fifo_rd", {31'd0, bus_a.fifo_rd}, 32'd0);
    chk("bp_m_valid", {31'd0, bus_a.m_valid}, 32'd1);
    chk("bp_m_data", {24'd0, bus_a.m_data}, 32'h01);
    m_ready = 1'b1;
    wait_deliv(base + 20, 100);
    if (log_q.size() >= base + 20) begin
      for (int i = 0; i < 20; i++) chk("bp_word", {24'd0, log_q[base + i]}, i + 1);
    end
    en = 1'b0;
    wait_idle(50);
    chk("bp_no_dup", log_q.size() - base, 20);

    // drain: en dropped one cycle after the first accepted read
    m_ready = 1'b0;
    base = log_q.size();
    acc0 = acc_cnt;
    load(8'hA0, 5);
    step();
    en = 1'b1;
    k = 0;
    while (acc_cnt == acc0 && k < 20) begin
      step();
      k++;
    end
    chk("drain_first_read", {31'd0, (acc_cnt > acc0)}, 32'd1);
    step();
    en = 1'b0;
    repeat (4) begin
      step();
      chk("drain_busy_held", {31'd0, busy_a}, 32'd1);
    end
    m_ready = 1'b1;
    wait_idle(30);
    chk("drain_accepted", acc_cnt - acc0, 3);
    chk("drain_delivered", log_q.size() - base, 3);
    if (log_q.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) chk("drain_word", {24'd0, log_q[base + i]}, 32'hA0 + i);
    end
    flush();
    step();

    // fifo_empty toggling every 2 cycles
    base = log_q.size();
    acc0 = acc_cnt;
    viol = 0;
    load(8'h30, 10);
    m_ready = 1'b1;
    step();
    en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      force_empty = ((i / 2) % 2) == 1;
      step();
    end
    force_empty = 1'b0;
    wait_deliv(base + 10, 100);
    en = 1'b0;
    wait_idle(50);
    chk("empty_violations", viol, 0);
    chk("empty_accepted", acc_cnt - acc0, 10);
    chk("empty_delivered", log_q.size() - base, 10);
    if (log_q.size() >= base + 10) begin
      for (int i = 0; i < 10; i++) chk("empty_word", {24'd0, log_q[base + i]}, 32'h30 + i);
    end

    // counter wrap, then reset mid-stream with two words buffered
    rst = 1'b0;
    step();
    rst = 1'b1;
    base = log_q.size();
    load(8'h01, 17);
    en = 1'b1;
    m_ready = 1'b1;
    wait_deliv(base + 17, 100);
    chk("wrap_cnt_b", {28'd0, cnt_b}, 32'd1);
    chk("wrap_cnt_a", {16'd0, cnt_a}, 32'd17);
    m_ready = 1'b0;
    load(8'h50, 10);
    k = 0;
    while (exp_q.size() != 2 && k < 20) begin
      step();
      k++;
    end
    chk("midrst_occ2", {31'd0, bus_a.m_valid}, 32'd1);
    rst = 1'b0;
    step();
    chk("midrst_m_valid", {31'd0, bus_a.m_valid}, 32'd0);
    chk("midrst_cnt_a", {16'd0, cnt_a}, 32'd0);
    chk("midrst_cnt_b", {28'd0, cnt_b}, 32'd0);
    chk("midrst_busy", {31'd0, busy_a}, 32'd0);
    chk("midrst_fifo_rd", {31'd0, bus_a.fifo_rd}, 32'd0);
    rst = 1'b1;
    en = 1'b0;
    flush();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the data width, matching the FIFO read port.
REQ-002 The block SHALL have parameter BUF_D, default 3, meaning the output buffer depth in words; the legal range is 2 to 8.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the transferred-word counter width.
REQ-004 The block SHALL have a single clock and a reset that is synchronous and active-low, on these ports:
- clk  input  1 : single clock; all logic is on its rising edge.
- rst  input  1 : synchronous reset, active-low.
REQ-005 The block SHALL have these ports:
- en  input  1 : enables reading from the FIFO.
- fifo_rd  output  1 : read request to the FIFO read port.
- fifo_empty  input  1 : registered empty flag from the FIFO.
- fifo_dout  input  DATA_W : FIFO read data; valid the cycle after an accepted read.
- m_data  output  DATA_W : output stream data.
- m_valid  output  1 : output stream valid.
- m_ready  input  1 : output stream ready.
- busy  output  1 : high when state is not IDLE.
- word_cnt  output  CNT_W : count of output handshakes completed.

Function
REQ-006 The block SHALL drive fifo_rd = (state==ACTIVE) & !fifo_empty & (occ + inflight < BUF_D), using only registers and fifo_empty, with no path from m_ready.
REQ-007 The block SHALL treat fifo_rd high at a clock edge as an accepted read, setting register inflight=1; otherwise inflight SHALL be cleared to 0.
REQ-008 The block SHALL write fifo_dout into the buffer tail on the cycle where inflight==1 (a one-cycle read latency), and SHALL increment occ.
REQ-009 The block SHALL drive m_valid = (occ != 0), and m_data SHALL equal the buffer head entry.
REQ-010 The block SHALL pop the head on m_valid & m_ready and decrement occ; a simultaneous push and pop SHALL leave occ unchanged.
REQ-011 While m_valid & !m_ready, m_data SHALL hold stable.
REQ-012 The block SHALL never overflow the buffer, because the (occ + inflight < BUF_D) gate guarantees occ <= BUF_D-1 at every push.
REQ-013 With BUF_D>=3, fifo_empty low and m_ready held high, the block SHALL sustain one word per cycle after a 2-cycle first-word latency, measured from fifo_rd to m_valid.
REQ-014 The block SHALL preserve word order exactly; buffer pointers SHALL wrap modulo BUF_D.
REQ-015 The state machine SHALL have these states and transitions:
- IDLE -> ACTIVE when en=1.
- ACTIVE -> DRAIN when en=0 and (occ!=0 or inflight=1).
- ACTIVE -> IDLE when en=0 and occ==0 and inflight==0.
- DRAIN -> ACTIVE when en=1.
- DRAIN -> IDLE when occ==0 and inflight==0.
REQ-016 In DRAIN and IDLE the block SHALL issue no new reads, and data already in flight or buffered SHALL still be delivered.
REQ-017 word_cnt SHALL increment by 1 on each m_valid & m_ready and wrap from 2^CNT_W-1 to 0.
REQ-018 If fifo_empty rises while inflight=1, the in-flight word SHALL still be captured.

Reset
REQ-019 When rst=0 at a clock edge, the block SHALL set state=IDLE, occ=0, inflight=0, pointers=0 and word_cnt=0, and clear all buffer entries to 0.
REQ-020 During and immediately after reset, the outputs SHALL be fifo_rd=0, m_valid=0, m_data=0, busy=0 and word_cnt=0.
REQ-021 A reset mid-operation SHALL discard buffered and in-flight words; the upstream FIFO SHALL share the same rst.

Structure
REQ-022 A shared package SHALL hold the state encodings (IDLE=2'b00, ACTIVE=2'b01, DRAIN=2'b10) and the default DATA_W/CNT_W constants.
REQ-023 The circular output buffer (storage, pointers, occ) SHALL be one sub-module named stream_buf; the FSM, read gating and counter SHALL stay in fifo_rd_stream.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset: rst=0 for 3 cycles with en=1 and fifo_empty=0 -> fifo_rd=0, m_valid=0 and word_cnt=0 throughout.
- Streaming: FIFO preloaded 0x01..0x10, en=1, m_ready=1 -> 16 words in order, one per cycle, first m_valid 2 cycles after the first fifo_rd, then word_cnt=16.
- Backpressure: m_ready=0 with 20 words available -> exactly BUF_D=3 words buffered, fifo_rd=0 afterwards, m_data=0x01 held; releasing m_ready resumes in order with no loss or duplicate.
- Drain: en dropped one cycle after a read is accepted -> busy stays high until the buffered and in-flight words are delivered, no further fifo_rd is issued, then state=IDLE and busy=0.
- Empty edge: fifo_empty toggled every 2 cycles -> fifo_rd is never high while fifo_empty=1, and every accepted word appears exactly once.
- Wrap and reset: with CNT_W=4, 17 transfers -> word_cnt=1; rst=0 mid-stream with occ=2 -> m_valid=0 on the next cycle and word_cnt=0.
